onehot_event_hist: RTL and testbench

- Downstream consumer of the 4-to-15 binary-to-one-hot encoder stage.
- Takes the encoder's 15-bit one-hot output and keeps a per-line saturating event histogram.
- Flags illegal multi-hot vectors.
- Exposes a serial dump port with valid/ready backpressure, so firmware-facing logic can read and optionally drain the counts without losing events.

---
 rtl/onehot_event_hist.sv | 163 ++++++++++++++++
 tb/tb_onehot_event_hist.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_event_hist.sv
// Per-line saturating event histogram fed by a one-hot encoder, with a sticky
// multi-hot error flag and a valid/ready serial dump port that can drain counts.
module onehot_event_hist #(
    parameter int N  = 15,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  oh_in,
    input  logic          clr,
    input  logic          dump_start,
    input  logic          clr_on_dump,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [3:0]    dump_idx,
    output logic [CW-1:0] dump_data,
    output logic          dump_last,
    output logic          busy,
    output logic          err_multi
);
    typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_t;

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    state_t               state_q, state_d;
    logic                 cod_q, cod_d;
    logic [3:0]           idx_q, idx_d;
    logic [CW-1:0]        data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic                 multi;
    logic [N-1:0]         ev;
    logic                 hs;
    logic [N-1:0][CW-1:0] cnt_nx;
    logic [3:0]           nxt_idx;
    logic [CW-1:0]        nxt_data;

    // x & (x-1) is non-zero exactly when two or more bits are set
    assign multi   = |(oh_in & (oh_in - N'(1)));
    assign ev      = multi ? '0 : oh_in;
    assign hs      = valid_q & dump_ready;
    assign nxt_idx = idx_q + 4'd1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cnt
            logic [CW-1:0] cnt_q, cnt_d;
            logic [CW:0]   sum;
            logic          drain;

            assign drain = hs & cod_q & (idx_q == 4'(gi));

            // Drain subtracts only what was reported, so events since the beat load survive
            always_comb begin
                if (drain) begin
                    sum = {1'b0, cnt_q} - {1'b0, data_q} + {{CW{1'b0}}, ev[gi]};
                end else begin
                    sum = {1'b0, cnt_q} + {{CW{1'b0}}, ev[gi]};
                end
                cnt_d = sum[CW] ? '1 : sum[CW-1:0];
                if (clr) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_nx[gi] = cnt_d;
        end
    endgenerate

    always_comb begin
        nxt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (nxt_idx == 4'(i)) begin
                nxt_data = cnt_nx[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cod_d   = cod_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q | multi;

        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = DUMP;
                    cod_d   = clr_on_dump;
                    idx_d   = 4'd0;
                    data_d  = cnt_nx[0];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            DUMP: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        data_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = nxt_idx;
                        data_d  = nxt_data;
                        last_d  = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d = IDLE;
            cod_d   = 1'b0;
            idx_d   = 4'd0;
            data_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cod_q   <= 1'b0;
            idx_q   <= 4'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cod_q   <= cod_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign dump_valid = valid_q;
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;
    assign dump_last  = last_q;
    assign busy       = (state_q != IDLE);
    assign err_multi  = err_q;
endmodule

// File: tb/tb_onehot_event_hist.sv
// Randomized and directed check of onehot_event_hist against an array-based
// histogram model evaluated every clock.
module tb_onehot_event_hist;
    localparam int N  = 15;
    localparam int CW = 8;
    localparam int MAXC = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  oh_in = '0;
    logic          clr = 1'b0;
    logic          dump_start = 1'b0;
    logic          clr_on_dump = 1'b0;
    logic          dump_ready = 1'b0;
    logic          dump_valid;
    logic [3:0]    dump_idx;
    logic [CW-1:0] dump_data;
    logic          dump_last;
    logic          busy;
    logic          err_multi;

    onehot_event_hist #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .oh_in(oh_in), .clr(clr),
        .dump_start(dump_start), .clr_on_dump(clr_on_dump), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_last(dump_last), .busy(busy), .err_multi(err_multi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    int m_cnt[N];
    int m_nc[N];
    bit m_valid = 1'b0;
    bit m_cod = 1'b0;
    bit m_err = 1'b0;
    int m_idx = 0;
    int m_data = 0;

    // Beats captured at handshake
    int cap_data[N];
    int cap_last[N];
    int cap_q[$];

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int pc;
        int evi;
        bit hsk;
        if (!rst) begin
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            m_valid = 0; m_cod = 0; m_err = 0; m_idx = 0; m_data = 0;
        end else if (clr) begin
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            m_valid = 0; m_cod = 0; m_err = 0; m_idx = 0; m_data = 0;
        end else begin
            pc  = $countones(oh_in);
            evi = -1;
            if (pc == 1) begin
                for (int k = 0; k < N; k++) if (oh_in[k]) evi = k;
            end
            hsk = m_valid && dump_ready;
            for (int k = 0; k < N; k++) begin
                if (hsk && m_cod && m_idx == k) m_nc[k] = m_cnt[k] - m_data + ((evi == k) ? 1 : 0);
                else m_nc[k] = m_cnt[k] + ((evi == k) ? 1 : 0);
                if (m_nc[k] > MAXC) m_nc[k] = MAXC;
            end
            if (pc >= 2) m_err = 1;
            if (!m_valid) begin
                if (dump_start) begin
                    m_valid = 1; m_cod = clr_on_dump; m_idx = 0; m_data = m_nc[0];
                end
            end else if (hsk) begin
                if (m_idx == N - 1) begin
                    m_valid = 0;
                end else begin
                    m_idx = m_idx + 1;
                    m_data = m_nc[m_idx];
                end
            end
            for (int k = 0; k < N; k++) m_cnt[k] = m_nc[k];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    // Compare process: outputs settle mid-cycle, inputs already hold next-edge values
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", dump_valid, m_valid);
            chk("busy", busy, m_valid);
            chk("last", dump_last, (m_valid && m_idx == N - 1) ? 1 : 0);
            chk("err", err_multi, m_err);
            if (m_valid) begin
                chk("idx", dump_idx, m_idx);
                chk("data", dump_data, m_data);
            end
            if (dump_valid && dump_ready && rst && !clr) begin
                cap_data[dump_idx] = dump_data;
                cap_last[dump_idx] = dump_last;
                cap_q.push_back(dump_idx);
                $display("beat idx=%0d data=%0d last=%0b", dump_idx, dump_data, dump_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_dump(bit cod, int mode);
        int pat[4] = '{1, 0, 0, 1};
        int n;
        cap_q.delete();
        for (int k = 0; k < N; k++) begin
            cap_data[k] = -1;
            cap_last[k] = 0;
        end
        dump_start = 1; clr_on_dump = cod; dump_ready = 1;
        tick();
        dump_start = 0;
        n = 0;
        while (busy && n < 200) begin
            dump_ready = (mode == 0) ? 1'b1 : pat[n % 4][0];
            tick();
            n++;
        end
        if (busy) chk("dump_timeout", busy, 0);
        dump_ready = 0;
        chk("nbeats", cap_q.size(), N);
        for (int k = 0; k < cap_q.size(); k++) chk("order", cap_q[k], k);
        for (int k = 0; k < N; k++) chk("lastflag", cap_last[k], (k == N - 1) ? 1 : 0);
    endtask

    initial begin
        int n;
        int a;
        int b;
        int r;

        // Reset and idle
        repeat (3) tick();
        chk("rst_valid", dump_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_multi, 0);
        rst = 1;
        repeat (10) tick();
        chk("idle_valid", dump_valid, 0);
        chk("idle_idx", dump_idx, 0);
        chk("idle_data", dump_data, 0);
        chk("idle_last", dump_last, 0);
        do_dump(0, 0);
        for (int k = 0; k < N; k++) chk("zero_dump", cap_data[k], 0);

        // Counting and saturation
        oh_in = 15'h0008;
        repeat (300) tick();
        oh_in = 15'h0001;
        repeat (5) tick();
        oh_in = '0;
        tick();
        do_dump(0, 0);
        for (int k = 0; k < N; k++)
            chk("sat_dump", cap_data[k], (k == 3) ? 255 : (k == 0) ? 5 : 0);
        chk("sat_err", err_multi, 0);

        // Multi-hot
        oh_in = 15'h0011;
        tick();
        oh_in = '0;
        chk("multi_err", err_multi, 1);
        repeat (3) tick();
        chk("multi_sticky", err_multi, 1);
        do_dump(0, 0);
        chk("multi_c0", cap_data[0], 5);
        chk("multi_c4", cap_data[4], 0);
        clr = 1;
        tick();
        clr = 0;
        chk("clr_err", err_multi, 0);

        // Backpressure
        oh_in = 15'h0004;
        repeat (7) tick();
        oh_in = '0;
        do_dump(0, 1);
        chk("bp_c2", cap_data[2], 7);

        // Drain with concurrent events
        clr = 1; tick(); clr = 0;
        oh_in = 15'h0020;
        repeat (10) tick();
        oh_in = '0;
        cap_q.delete();
        dump_start = 1; clr_on_dump = 1; dump_ready = 1;
        tick();
        dump_start = 0;
        n = 0;
        while (dump_idx != 4'd5 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_reach5", dump_idx, 5);
        dump_ready = 0;
        oh_in = 15'h0020;
        repeat (3) tick();
        chk("drain_hold", dump_data, 10);
        dump_ready = 1;
        tick();
        oh_in = '0;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("drain_done", busy, 0);
        chk("drain_beat5", cap_data[5], 10);
        dump_ready = 0;
        do_dump(0, 0);
        chk("drain_after", cap_data[5], 4);

        // clr mid-dump
        oh_in = 15'h0200;
        repeat (5) tick();
        oh_in = '0;
        dump_start = 1; clr_on_dump = 0; dump_ready = 1;
        tick();
        dump_start = 0;
        n = 0;
        while (dump_idx != 4'd6 && n < 50) begin
            tick();
            n++;
        end
        chk("clr_reach6", dump_idx, 6);
        clr = 1;
        tick();
        clr = 0;
        dump_ready = 0;
        chk("clr_valid", dump_valid, 0);
        chk("clr_busy", busy, 0);
        do_dump(0, 0);
        for (int k = 0; k < N; k++) chk("clr_dump", cap_data[k], 0);

        // Randomized traffic, with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                oh_in = '0;
            end else if (r < 96) begin
                oh_in = 15'(1) << $urandom_range(0, N - 1);
            end else begin
                a = $urandom_range(0, N - 1);
                b = (a + 1 + $urandom_range(0, N - 2)) % N;
                oh_in = (15'(1) << a) | (15'(1) << b);
            end
            dump_start  = ($urandom_range(0, 19) == 0);
            clr_on_dump = $urandom_range(0, 1) == 1;
            dump_ready  = ($urandom_range(0, 2) != 0);
            clr         = ($urandom_range(0, 299) == 0);
            if (i == 1500) begin
                #2 rst = 0;
                #1;
                chk("arst_valid", dump_valid, 0);
                chk("arst_busy", busy, 0);
                chk("arst_err", err_multi, 0);
                tick();
                #2 rst = 1;
            end
            tick();
        end
        oh_in = '0; dump_start = 0; clr = 0; dump_ready = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
